// File: rtl/par_frame_pkg.sv
// Shared types and constants for the par_frame_tx serial framer.
// The optional transmit-side parity check (enabled with PAR_FRAME_TX_CHECK_EN)
// uses byte_parity() from this package.
package par_frame_pkg;

    // Framer FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line parity bit: the upstream XOR-reduction is already "even" parity,
    // so odd framing simply inverts it.
    function automatic logic frame_parity(input logic parity_in, input logic par_sel);
        logic par_s;
        if (par_sel == PAR_ODD) begin
            par_s = ~parity_in;
        end else begin
            par_s = parity_in;
        end
        return par_s;
    endfunction

    // XOR-reduction of a data byte (1 = odd number of ones)
    function automatic logic byte_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/par_frame_tx_if.sv
// Upstream byte handshake between the parity generator and the framer.
// master = upstream producer, slave = par_frame_tx.
interface par_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] din;
    logic              parity_in;
    logic              par_sel;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output din,
        output parity_in,
        output par_sel,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  din,
        input  parity_in,
        input  par_sel,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/par_frame_baud.sv
// Baud timer for par_frame_tx: counts 0..CLKS_PER_BIT-1 and flags the last
// cycle of every bit period. Held at zero while clear is high so the first
// bit of a frame always gets a full period.
module par_frame_baud #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);
    localparam int               CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_term;

    assign w_at_term = (r_cnt == TERM);
    assign bit_tick  = w_at_term && !clear;

    // Bit-period counter: reload at every bit boundary, hold zero when cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clear) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_at_term) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/par_frame_tx.sv
// par_frame_tx: serial framer behind the byte parity generator.
// Frame on tx (LSB first): start(0), 8 data bits, parity, stop(1), each bit
// held CLKS_PER_BIT clocks. All outputs are registered.
// Optional feature macro: PAR_FRAME_TX_CHECK_EN adds par_err, which flags a
// parity_in that disagrees with the XOR-reduction of din at transfer time.
module par_frame_tx
    import par_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    par_frame_tx_if.slave        bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
`ifdef PAR_FRAME_TX_CHECK_EN
    ,
    output logic                 par_err
`endif
);
    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_par_bit;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
    logic                r_in_ready;

    logic                w_xfer;
    logic                w_bit_tick;
    logic                w_baud_clear;

    assign w_xfer       = bus.in_valid && r_in_ready;
    assign w_baud_clear = (r_state == IDLE);

    par_frame_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_baud_clear),
        .bit_tick (w_bit_tick)
    );

    // Framer FSM with registered line, status and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= {DATA_W{1'b0}};
            r_bit_idx  <= {IDX_W{1'b0}};
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_state    <= START;
                        r_shift    <= bus.din;
                        r_bit_idx  <= {IDX_W{1'b0}};
                        r_par_bit  <= frame_parity(bus.parity_in, bus.par_sel);
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                    end else begin
                        r_tx <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_tx <= r_tx;
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_tx <= r_par_bit;
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        r_state    <= IDLE;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_busy <= 1'b1;
                    end
                    r_tx <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: recover to an idle line
                    r_state    <= IDLE;
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PAR_FRAME_TX_CHECK_EN
    logic r_par_err;

    // Capture a parity_in/din disagreement at each transfer, hold until the next
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_xfer) begin
            r_par_err <= (bus.parity_in != byte_parity(bus.din));
        end else begin
            r_par_err <= r_par_err;
        end
    end

    assign par_err = r_par_err;
`endif

    assign tx           = r_tx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bus.in_ready = r_in_ready;

endmodule

// File: tb/tb_par_frame_tx.sv
// Self-checking bench for par_frame_tx (CLKS_PER_BIT = 4).
// Expected line images come from a frame model built from the framing rules;
// builds with PAR_FRAME_TX_CHECK_EN also check par_err.
module tb_par_frame_tx;
    import par_frame_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk;
    logic rst;
    logic tx;
    logic busy;
    logic done;
`ifdef PAR_FRAME_TX_CHECK_EN
    logic par_err;
`endif

    int n_tests;
    int n_fail;

    par_frame_tx_if #(.DATA_W(8)) bus ();

    par_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
`ifdef PAR_FRAME_TX_CHECK_EN
        ,
        .par_err (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line image of one frame, index = bit slot: start, d[0..7], parity, stop
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        b[9]  = p ^ s;
        b[10] = 1'b1;
        return b;
    endfunction

    // Present a byte at a negedge; return at the negedge after the transfer edge
    task automatic send(input logic [7:0] d, input logic p, input logic s);
        bus.din       = d;
        bus.parity_in = p;
        bus.par_sel   = s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.din      = 8'hA5;
        bus.parity_in = 1'b0;
        bus.par_sel  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: tx=%b busy=%b done=%b in_ready=%b, want 1 0 0 1",
                         c, tx, busy, done, bus.in_ready);
            end
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_xfer: tx=%b busy=%b in_ready=%b, want 1 0 1", tx, busy, bus.in_ready);
        end
    endtask

    // One complete frame from an idle negedge, ending at an idle negedge
    task automatic test_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
        logic [10:0] exp_bits;
        logic        exp_err;
        exp_bits = frame_bits(d, p, s);
        exp_err  = (p != (($countones(d) % 2) == 1));
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: in_ready=%b, want 1", tag, bus.in_ready);
        end
        send(d, p, s);
        // Inputs change under a frame in progress and must be ignored
        bus.in_valid  = 1'b0;
        bus.din       = ~d;
        bus.parity_in = ~p;
        bus.par_sel   = ~s;
`ifdef PAR_FRAME_TX_CHECK_EN
        n_tests++;
        if (par_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s par_err: got %b, want %b", tag, par_err, exp_err);
        end
`endif
        for (int k = 0; k < FRAME_CYC; k++) begin
            n_tests++;
            if (tx !== exp_bits[k / CPB] || busy !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cyc%0d: tx=%b busy=%b done=%b rdy=%b, want tx=%b busy=1 done=0 rdy=0",
                         tag, k, tx, busy, done, bus.in_ready, exp_bits[k / CPB]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || tx !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_cycle: done=%b tx=%b busy=%b rdy=%b, want 1 1 0 1",
                     tag, done, tx, busy, bus.in_ready);
        end
`ifdef PAR_FRAME_TX_CHECK_EN
        n_tests++;
        if (par_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s par_err_hold: got %b, want %b", tag, par_err, exp_err);
        end
`endif
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b tx=%b busy=%b, want 0 1 0", tag, done, tx, busy);
        end
    endtask

    task automatic test_even_frame();
        test_frame("even_A5", 8'hA5, 1'b0, PAR_EVEN);
    endtask

    task automatic test_odd_frames();
        test_frame("odd_07", 8'h07, 1'b1, PAR_ODD);
        test_frame("odd_00", 8'h00, 1'b0, PAR_ODD);
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic       p;
        logic       s;
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            p = 1'(($countones(d) % 2) == 1);
            if ($urandom_range(0, 3) == 0) p = ~p;
            test_frame("random", d, p, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] b1;
        logic [10:0] b2;
        logic        s;
        s  = 1'($urandom_range(0, 1));
        b1 = frame_bits(8'h3C, 1'b0, s);
        b2 = frame_bits(8'hFF, 1'b0, s);
        send(8'h3C, 1'b0, s);
        bus.din = 8'hFF;
        for (int k = 0; k < FRAME_CYC; k++) begin
            n_tests++;
            if (tx !== b1[k / CPB] || bus.in_ready !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_first cyc%0d: tx=%b rdy=%b done=%b, want tx=%b rdy=0 done=0",
                         k, tx, bus.in_ready, done, b1[k / CPB]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (tx !== 1'b1 || done !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: tx=%b done=%b rdy=%b, want 1 1 1", tx, done, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            n_tests++;
            if (tx !== b2[k / CPB] || bus.in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_second cyc%0d: tx=%b rdy=%b done=%b busy=%b, want tx=%b rdy=0 done=0 busy=1",
                         k, tx, bus.in_ready, done, busy, b2[k / CPB]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b rdy=%b, want 1 1", done, bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic saw_done;
        logic saw_low;
        send(8'hF0, 1'b0, PAR_EVEN);
        bus.in_valid = 1'b0;
        // Cycle 17 sits inside data bit 3 (cycles 16..19); bit 3 of F0 is 0
        repeat (17) @(negedge clk);
        n_tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_bit3: tx=%b busy=%b, want 0 1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_abort: tx=%b busy=%b done=%b rdy=%b, want 1 0 0 1",
                     tx, busy, done, bus.in_ready);
        end
        rst      = 1'b0;
        saw_done = 1'b0;
        saw_low  = 1'b0;
        for (int k = 0; k < FRAME_CYC + 8; k++) begin
            if (done === 1'b1) saw_done = 1'b1;
            if (tx !== 1'b1) saw_low = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (saw_done !== 1'b0 || saw_low !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: saw_done=%b saw_low=%b, want 0 0", saw_done, saw_low);
        end
        test_frame("after_rst_55", 8'h55, 1'b0, 1'($urandom_range(0, 1)));
    endtask

`ifdef PAR_FRAME_TX_CHECK_EN
    task automatic test_par_check();
        test_frame("chk_01", 8'h01, 1'b0, PAR_EVEN);
        test_frame("chk_03", 8'h03, 1'b0, PAR_EVEN);
    endtask
`endif

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = 8'h00;
        bus.parity_in = 1'b0;
        bus.par_sel   = 1'b0;
        test_reset();
        test_even_frame();
        test_odd_frames();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PAR_FRAME_TX_CHECK_EN
        test_par_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
